// File: rtl/coefficient_loader.sv
// Streams one filter's MASK_WIDTH^2 coefficients from the coefficient ROM into the shift-write
// coefficient file, then flags the file valid. Optional feature macro: COEF_CHECKSUM_EN.
module coefficient_loader #(
    parameter int COFCNT_BIT     = 16,
    parameter int MASK_WIDTH     = 7,
    parameter int FILTER_SEL_BIT = 3,
    parameter int IDX_BIT        = 6
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              load_req,
    input  logic [FILTER_SEL_BIT-1:0]         load_sel,
    output logic                              load_ack,
    output logic                              busy,
    output logic                              done,
    output logic [FILTER_SEL_BIT-1:0]         active_sel,
    output logic                              coef_valid,
    output logic                              rom_rd_en,
    output logic [FILTER_SEL_BIT+IDX_BIT-1:0] rom_addr,
    input  logic [COFCNT_BIT-1:0]             rom_data,
    output logic                              cf_wr_en,
    output logic [COFCNT_BIT-1:0]             cf_wr_data
`ifdef COEF_CHECKSUM_EN
    ,
    output logic [COFCNT_BIT+IDX_BIT-1:0]     checksum
`endif
);

    localparam int                 N        = MASK_WIDTH * MASK_WIDTH;
    localparam logic [IDX_BIT-1:0] LAST_IDX = IDX_BIT'(N - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    logic [1:0]         state;
    logic [IDX_BIT-1:0] idx;
    logic               accept;

    assign accept    = (state == IDLE) && load_req;
    assign busy      = (state != IDLE);
    assign rom_rd_en = (state == FETCH);
    assign rom_addr  = {active_sel, idx};

    // The ROM output is already registered and lines up with the delayed read strobe;
    // gating keeps the write bus at zero whenever no write is taking place.
    assign cf_wr_data = cf_wr_en ? rom_data : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            active_sel <= '0;
            load_ack   <= 1'b0;
            done       <= 1'b0;
            cf_wr_en   <= 1'b0;
            coef_valid <= 1'b0;
        end else begin
            load_ack <= accept;
            done     <= (state == FLUSH);
            cf_wr_en <= (state == FETCH);
            case (state)
                IDLE: begin
                    if (load_req) begin
                        active_sel <= load_sel;
                        idx        <= '0;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    // Issuing index 0 now means its write lands next cycle: drop valid with it.
                    if (idx == '0) begin
                        coef_valid <= 1'b0;
                    end
                    if (idx == LAST_IDX) begin
                        state <= FLUSH;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                FLUSH: begin
                    state      <= IDLE;
                    coef_valid <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef COEF_CHECKSUM_EN
    // Accept and a write never coincide: the last write happens in the flush cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= '0;
        end else if (cf_wr_en) begin
            checksum <= checksum + {{IDX_BIT{1'b0}}, cf_wr_data};
        end
    end
`endif

endmodule

// File: tb/tb_coefficient_loader.sv
// Self-checking bench for coefficient_loader: cycle-offset reference model, ROM and shift-in file model.
// Build with COEF_CHECKSUM_EN defined to also exercise the checksum port.
`timescale 1ns/1ps
module tb_coefficient_loader;

    localparam int W   = 16;
    localparam int MW  = 7;
    localparam int SB  = 3;
    localparam int IB  = 6;
    localparam int N   = MW * MW;
    localparam int SIB = 4;
    localparam int SN  = 9;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic              load_req = 1'b0;
    logic [SB-1:0]     load_sel = '0;
    logic              load_ack, busy, done, coef_valid, rom_rd_en, cf_wr_en;
    logic [SB-1:0]     active_sel;
    logic [SB+IB-1:0]  rom_addr;
    logic [W-1:0]      rom_data = '0;
    logic [W-1:0]      cf_wr_data;
`ifdef COEF_CHECKSUM_EN
    logic [W+IB-1:0]   checksum;
`endif

    logic              s_load_req = 1'b0;
    logic [SB-1:0]     s_load_sel = '0;
    logic              s_load_ack, s_busy, s_done, s_coef_valid, s_rom_rd_en, s_cf_wr_en;
    logic [SB-1:0]     s_active_sel;
    logic [SB+SIB-1:0] s_rom_addr;
    logic [W-1:0]      s_rom_data = '0;
    logic [W-1:0]      s_cf_wr_data;
`ifdef COEF_CHECKSUM_EN
    logic [W+SIB-1:0]  s_checksum;
`endif

    coefficient_loader #(.COFCNT_BIT(W), .MASK_WIDTH(MW), .FILTER_SEL_BIT(SB), .IDX_BIT(IB)) dut (
        .clk(clk), .reset(reset), .load_req(load_req), .load_sel(load_sel),
        .load_ack(load_ack), .busy(busy), .done(done), .active_sel(active_sel),
        .coef_valid(coef_valid), .rom_rd_en(rom_rd_en), .rom_addr(rom_addr),
        .rom_data(rom_data), .cf_wr_en(cf_wr_en), .cf_wr_data(cf_wr_data)
`ifdef COEF_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    coefficient_loader #(.COFCNT_BIT(W), .MASK_WIDTH(3), .FILTER_SEL_BIT(SB), .IDX_BIT(SIB)) dut_small (
        .clk(clk), .reset(reset), .load_req(s_load_req), .load_sel(s_load_sel),
        .load_ack(s_load_ack), .busy(s_busy), .done(s_done), .active_sel(s_active_sel),
        .coef_valid(s_coef_valid), .rom_rd_en(s_rom_rd_en), .rom_addr(s_rom_addr),
        .rom_data(s_rom_data), .cf_wr_en(s_cf_wr_en), .cf_wr_data(s_cf_wr_data)
`ifdef COEF_CHECKSUM_EN
        , .checksum(s_checksum)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [W-1:0] rom_tbl [0:(1<<(SB+IB))-1];
    logic [W-1:0] file_q  [0:N-1];
    logic [W-1:0] sfile_q [0:SN-1];
    int           s_wr_count = 0;
    int           s_bad_sel = 0;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, actual, expected);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ROMs answer one cycle after the read strobe; the coefficient files shift in at the top.
    always @(posedge clk) begin
        if (rom_rd_en) rom_data <= rom_tbl[rom_addr];
        if (s_rom_rd_en) begin
            s_rom_data <= W'(s_rom_addr[SIB-1:0]) + 16'd7;
            if (s_rom_addr[SB+SIB-1:SIB] != 3'd6) s_bad_sel <= s_bad_sel + 1;
        end
        if (cf_wr_en) begin
            for (int k = 0; k < N - 1; k++) file_q[k] <= file_q[k+1];
            file_q[N-1] <= cf_wr_data;
        end
        if (s_cf_wr_en) begin
            for (int k = 0; k < SN - 1; k++) sfile_q[k] <= sfile_q[k+1];
            sfile_q[SN-1] <= s_cf_wr_data;
            s_wr_count <= s_wr_count + 1;
        end
    end

    // Reference model: m_t is the current cycle's offset from the accepting cycle c.
    bit            m_on = 1'b0;
    int            m_t = 0;
    logic [SB-1:0] m_sel = '0;
    bit            m_valid = 1'b0;
`ifdef COEF_CHECKSUM_EN
    logic [W+IB-1:0] m_sum = '0;
`endif

    always @(posedge clk) begin
        if (reset) begin
            m_on    <= 1'b0;
            m_t     <= 0;
            m_sel   <= '0;
            m_valid <= 1'b0;
`ifdef COEF_CHECKSUM_EN
            m_sum   <= '0;
`endif
        end else if ((!m_on || m_t == N + 2) && load_req) begin
            m_on  <= 1'b1;
            m_t   <= 1;
            m_sel <= load_sel;
`ifdef COEF_CHECKSUM_EN
            m_sum <= '0;
`endif
        end else if (m_on) begin
            if (m_t == N + 2) m_on <= 1'b0;
            else m_t <= m_t + 1;
            if (m_t == 1) m_valid <= 1'b0;
            if (m_t == N + 1) m_valid <= 1'b1;
`ifdef COEF_CHECKSUM_EN
            if (m_t >= 2 && m_t <= N + 1) m_sum <= m_sum + W'(rom_tbl[{m_sel, IB'(m_t - 2)}]);
`endif
        end
    end

    always @(negedge clk) begin : compare
        bit e_rd;
        bit e_wr;
        bit e_done;
        int nbad;
        if (cyc > 0) begin
            e_rd   = m_on && m_t >= 1 && m_t <= N;
            e_wr   = m_on && m_t >= 2 && m_t <= N + 1;
            e_done = m_on && m_t == N + 2;
            check_output("load_ack", load_ack, m_on && m_t == 1);
            check_output("busy", busy, m_on && m_t >= 1 && m_t <= N + 1);
            check_output("rom_rd_en", rom_rd_en, e_rd);
            check_output("cf_wr_en", cf_wr_en, e_wr);
            check_output("done", done, e_done);
            check_output("active_sel", active_sel, m_sel);
            check_output("coef_valid", coef_valid, m_valid);
            if (e_rd) check_output("rom_addr", rom_addr, {m_sel, IB'(m_t - 1)});
            if (e_wr) check_output("cf_wr_data", cf_wr_data, rom_tbl[{m_sel, IB'(m_t - 2)}]);
`ifdef COEF_CHECKSUM_EN
            check_output("checksum", checksum, m_sum);
`endif
            if (e_done) begin
                nbad = 0;
                for (int k = 0; k < N; k++)
                    if (file_q[k] !== rom_tbl[{m_sel, IB'(k)}]) nbad++;
                check_output("file_bad_slots", nbad, 0);
            end
        end
    end

    task automatic fill_rom(input int mode);
        for (int a = 0; a < (1 << (SB + IB)); a++) begin
            if (mode == 0) rom_tbl[a] = W'(a % 64) + 16'd100;
            else if (mode == 1) rom_tbl[a] = W'(a % 64) + 16'd1;
            else rom_tbl[a] = W'($urandom);
        end
    endtask

    task automatic apply_stimulus(input logic [SB-1:0] sel, output int req_cyc);
        load_sel = sel;
        load_req = 1'b1;
        req_cyc  = cyc;
    endtask

    task automatic wait_ack();
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (load_ack !== 1'b1 && n < 200);
        check_output("ack_within_bound", n < 200, 1);
        load_req = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (done !== 1'b1 && n < 200);
        check_output("done_within_bound", n < 200, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_busy"}, busy, 0);
        check_output({tag, "_load_ack"}, load_ack, 0);
        check_output({tag, "_done"}, done, 0);
        check_output({tag, "_rom_rd_en"}, rom_rd_en, 0);
        check_output({tag, "_rom_addr"}, rom_addr, 0);
        check_output({tag, "_cf_wr_en"}, cf_wr_en, 0);
        check_output({tag, "_cf_wr_data"}, cf_wr_data, 0);
        check_output({tag, "_active_sel"}, active_sel, 0);
        check_output({tag, "_coef_valid"}, coef_valid, 0);
`ifdef COEF_CHECKSUM_EN
        check_output({tag, "_checksum"}, checksum, 0);
`endif
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int c;
        int d;
        int n;
        fill_rom(0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        reset = 1'b0;
        @(posedge clk); #1;

        // Sel-2 load with a sel-5 request held from the ack onward.
        apply_stimulus(3'd2, c);
        wait_ack();
        check_output("sel2_ack_latency", cyc - c, 1);
        load_sel = 3'd5;
        load_req = 1'b1;
        wait_done();
        d = cyc;
        check_output("sel2_done_latency", cyc - c, 51);
        check_output("sel2_slot0", file_q[0], 100);
        check_output("sel2_slot48", file_q[48], 148);
        wait_ack();
        check_output("b2b_ack_after_done", cyc - d, 1);
        check_output("sel5_active_sel", active_sel, 5);
        wait_done();

        // Reset in the cycle of the 20th write.
        @(posedge clk); #1;
        apply_stimulus(3'd3, c);
        wait_ack();
        n = 0;
        for (int g = 0; g < 200 && n < 20; g++) begin
            @(negedge clk);
            if (cf_wr_en) n++;
        end
        check_output("reached_20_writes", n, 20);
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("midload");
        reset = 1'b0;
        @(posedge clk); #1;
        apply_stimulus(3'd1, c);
        wait_ack();
        wait_done();
        check_output("sel1_done_latency", cyc - c, 51);
        check_output("sel1_active_sel", active_sel, 1);

        // idx+1 content: checksum of 1..49.
        @(posedge clk); #1;
        fill_rom(1);
        apply_stimulus(3'd4, c);
        wait_ack();
        wait_done();
        check_output("sel4_slot0", file_q[0], 1);
        check_output("sel4_slot48", file_q[48], 49);
`ifdef COEF_CHECKSUM_EN
        check_output("checksum_1225", checksum, 1225);
`endif

        // Randomized loads, often requested while the previous one is still running.
        @(posedge clk); #1;
        fill_rom(2);
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
            apply_stimulus(SB'($urandom_range(0, 7)), c);
            wait_ack();
        end
        wait_done();
        repeat (3) @(posedge clk);

        // 3x3 instance: 9 writes, done at c+11.
        #1;
        s_load_sel = 3'd6;
        s_load_req = 1'b1;
        c = cyc;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (s_load_ack) s_load_req = 1'b0;
        end while (s_done !== 1'b1 && n < 100);
        check_output("small_done_latency", cyc - c, 11);
        check_output("small_write_count", s_wr_count, 9);
        check_output("small_slot0", sfile_q[0], 7);
        check_output("small_slot8", sfile_q[8], 15);
        check_output("small_active_sel", s_active_sel, 6);
        check_output("small_coef_valid", s_coef_valid, 1);
        check_output("small_rom_sel_bits", s_bad_sel, 0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/coefficient_loader.md
# coefficient_loader

Sequencing controller that fills the 7x7 coefficient register file from an external coefficient ROM holding one coefficient set per filter. On a handshaked load request it streams all MASK_WIDTH² coefficients of the selected filter into the file, in index order, through the file's shift-write port. It then flags the file contents as valid, so the filter datapath only consumes a complete, consistent mask.

## Interface
- COFCNT_BIT, 16, coefficient width in bits
- MASK_WIDTH, 7, mask side; N = MASK_WIDTH² coefficients per set
- FILTER_SEL_BIT, 3, filter-select width (up to 8 stored sets)
- IDX_BIT, 6, coefficient index width; 2^IDX_BIT ≥ N

- clk  in  1  clock; one clock domain, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- load_req  in  1  load request; held high by requester until load_ack
- load_sel  in  FILTER_SEL_BIT  filter to load; sampled with accepted load_req
- load_ack  out  1  one-cycle pulse: request accepted
- busy  out  1  load in progress
- done  out  1  one-cycle pulse: full set written
- active_sel  out  FILTER_SEL_BIT  filter of the last accepted load
- coef_valid  out  1  coefficient file holds a complete set
- rom_rd_en  out  1  ROM read strobe
- rom_addr  out  FILTER_SEL_BIT+IDX_BIT  {active_sel, idx}
- rom_data  in  COFCNT_BIT  ROM data, valid exactly 1 cycle after rom_rd_en
- cf_wr_en  out  1  coefficient file write enable
- cf_wr_data  out  COFCNT_BIT  coefficient file write data (registered rom_data)
- checksum  out  COFCNT_BIT+IDX_BIT  present only with COEF_CHECKSUM_EN

## Operation
- States: IDLE, FETCH, FLUSH.
  - IDLE: when load_req = 1, latch load_sel into active_sel, clear idx and checksum, go to FETCH.
  - FETCH: rom_rd_en = 1, rom_addr = {active_sel, idx}, idx increments by 1 per cycle. After idx = N-1 is issued, go to FLUSH.
  - FLUSH: one cycle, then go to IDLE.
- Write pipeline: cf_wr_en is rom_rd_en delayed one cycle; cf_wr_data = rom_data.
- Write order: index 0 is written first. The file shifts in at its top, so after N writes index 0 occupies the lowest slot, bits [COFCNT_BIT-1:0].
- coef_valid:
  - Clears in the cycle of the first cf_wr_en of a load.
  - Sets together with done.
- Requests are accepted only in IDLE. A load_req while busy is neither acked nor queued; the requester keeps holding it.
- idx counts 0..N-1 only and never wraps within a load.
- Reset at any time, including mid-load:
  - State goes to IDLE.
  - load_ack, busy, done, rom_rd_en, cf_wr_en, coef_valid, idx, active_sel, cf_wr_data and checksum all go to 0.
  - The coefficient file itself has no reset, so coef_valid stays 0 until a full load completes.

## Timing
- In this section, c is the cycle in which IDLE samples load_req = 1.
- Cycle c+1:
  - load_ack pulses.
  - busy rises.
  - First rom_rd_en is issued (idx 0).
- Cycles c+1..c+N: rom_rd_en high, with idx k issued in cycle c+1+k.
- Cycles c+2..c+N+1: cf_wr_en high, N consecutive writes with no gaps.
- Cycle c+N+2:
  - done pulses and coef_valid rises.
  - busy is low.
  - The file holds all N values.
  - IDLE can accept a new request in this same cycle.
- Latency from request to done is N+2 cycles; 51 for the defaults.
- Back-to-back loads: with load_req held high, the next load_ack follows the previous done by one cycle.

## Configuration
- COEF_CHECKSUM_EN defined:
  - checksum accumulates the unsigned sum of every written cf_wr_data, modulo 2^(COFCNT_BIT+IDX_BIT).
  - It is cleared on accept and is final in the cycle done pulses.
  - It holds its value until the next accept or reset.
- COEF_CHECKSUM_EN undefined: the checksum port and adder are absent; all other behaviour is identical.

## Test plan
- Reset, then load_req with load_sel = 2 at cycle c; ROM returns idx+100:
  - rom_addr = {2,0}..{2,48} in cycles c+1..c+49.
  - 49 cf_wr_en pulses.
  - done and coef_valid at c+51.
  - File slot 0 = 100, slot 48 = 148.
- Hold load_req with load_sel = 5 high during a sel-2 load: no ack until the cycle after done; sel 5 then loads with active_sel = 5.
- Assert reset at the 20th write:
  - Next cycle, all outputs are 0 and coef_valid = 0.
  - A following sel-1 load completes normally in 51 cycles.
- Request in the same cycle done pulses: load_ack the next cycle, and coef_valid drops on that load's first write.
- With COEF_CHECKSUM_EN and ROM returning idx+1: checksum = 1225 at done; without the macro the checksum port is absent and the build still succeeds.
- MASK_WIDTH = 3, IDX_BIT = 4: 9 writes, done at c+11, slot 0 = index 0 value.
